// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
//   Shared definitions for the simple processor control path and datapath.
//   The bus multiplexer consumes the same SEL_* codes that the control FSM
//   drives, so both sides stay consistent from this single source.
//   Contents:
//     SEL_*   : bus multiplexer select codes
//     OP_*    : instruction opcodes (IR[15:13])
//     ALU_*   : ALU operation codes
//     state_t : control FSM timestep T0..T3
//     alu_op_of() : maps an ALU-class opcode to its ALU operation code
// ---------------------------------------------------------------------------
package proc_pkg;

  // Bus multiplexer select codes
  localparam logic [3:0] SEL_R0 = 4'd0;
  localparam logic [3:0] SEL_R1 = 4'd1;
  localparam logic [3:0] SEL_R2 = 4'd2;
  localparam logic [3:0] SEL_R3 = 4'd3;
  localparam logic [3:0] SEL_R4 = 4'd4;
  localparam logic [3:0] SEL_R5 = 4'd5;
  localparam logic [3:0] SEL_R6 = 4'd6;
  localparam logic [3:0] SEL_R7 = 4'd7;
  localparam logic [3:0] SEL_G  = 4'd8;   // ALU result register G
  localparam logic [3:0] SEL_D  = 4'd9;   // zero-extended IR[8:0]
  localparam logic [3:0] SEL_DT = 4'd10;  // {IR[7:0], 8'h00}

  // Opcodes; 6 and 7 are illegal
  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_MVT = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  function automatic logic [1:0] alu_op_of(input logic [2:0] opcode);
    case (opcode)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_control_fsm_ir_decode.sv
// ---------------------------------------------------------------------------
// ir_decode
//   Purely combinational instruction decoder. It receives only the IR fields
//   the control path interprets; the immediate bits go straight from the IR
//   to the bus multiplexer and are not decoded here.
//   Ports:
//     i_op        [2:0]      : IR[15:13], opcode field
//     i_rx        [2:0]      : IR[11:9],  rX register index
//     i_ry        [2:0]      : IR[2:0],   rY register index
//     o_opcode    [2:0]      : opcode
//     o_rx        [2:0]      : rX index (used as a bus select in T1)
//     o_rx_onehot [NREG-1:0] : one-hot load enable for rX
//     o_ry        [2:0]      : rY index
//     o_illegal              : opcode is not one of mv/mvi/add/sub/mvt/and
// ---------------------------------------------------------------------------
module ir_decode
  import proc_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic [2:0]      i_op,
  input  logic [2:0]      i_rx,
  input  logic [2:0]      i_ry,
  output logic [2:0]      o_opcode,
  output logic [2:0]      o_rx,
  output logic [NREG-1:0] o_rx_onehot,
  output logic [2:0]      o_ry,
  output logic            o_illegal
);

  assign o_opcode = i_op;
  assign o_rx     = i_rx;
  assign o_ry     = i_ry;

  always_comb begin
    o_rx_onehot       = '0;
    o_rx_onehot[i_rx] = 1'b1;
  end

  always_comb begin
    case (i_op)
      OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVT, OP_AND: o_illegal = 1'b0;
      default:                                       o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/proc_control_fsm.sv
// ---------------------------------------------------------------------------
// proc_control_fsm
//   Control unit for the simple processor datapath. Latches an instruction
//   into IR when run is seen in T0, then steps through T1..T3 driving the bus
//   multiplexer select, register load enables, A/G enables and the ALU op.
//   done pulses in the final cycle of every instruction; the following T0
//   can accept the next run immediately.
//   Ports:
//     clk            : system clock, rising edge
//     reset          : synchronous, active-high
//     run            : start request, sampled only in T0
//     instr  [IR_W]  : instruction word, captured into IR on accept
//     ir     [IR_W]  : registered IR, feeds the mux immediate paths
//     bus_sel[3:0]   : bus multiplexer select (SEL_* codes)
//     r_in   [NREG]  : one-hot load enable for r0..r7
//     a_in           : load A from bus
//     g_in           : load G from ALU
//     alu_op [1:0]   : ALU operation, meaningful only with g_in
//     done           : one-cycle completion pulse
// ---------------------------------------------------------------------------
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int IR_W = 16,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [IR_W-1:0] instr,
  output logic [IR_W-1:0] ir,
  output logic [3:0]      bus_sel,
  output logic [NREG-1:0] r_in,
  output logic            a_in,
  output logic            g_in,
  output logic [1:0]      alu_op,
  output logic            done
);

  state_t          r_state;
  state_t          w_next;
  logic [IR_W-1:0] r_ir;

  logic [2:0]      w_opcode;
  logic [2:0]      w_rx;
  logic [NREG-1:0] w_rx_onehot;
  logic [2:0]      w_ry;
  logic            w_illegal;

  ir_decode #(
    .NREG(NREG)
  ) u_ir_decode (
    .i_op       (r_ir[15:13]),
    .i_rx       (r_ir[11:9]),
    .i_ry       (r_ir[2:0]),
    .o_opcode   (w_opcode),
    .o_rx       (w_rx),
    .o_rx_onehot(w_rx_onehot),
    .o_ry       (w_ry),
    .o_illegal  (w_illegal)
  );

  assign ir = r_ir;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      // IR only moves on an accepted run; it is frozen for the rest of
      // the instruction regardless of what instr does.
      if (r_state == T0 && run) begin
        r_ir <= instr;
      end
    end
  end

  // Outputs depend only on state and IR; instr never reaches an output
  // combinationally.
  always_comb begin
    w_next  = r_state;
    bus_sel = SEL_R0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_op  = ALU_ADD;
    done    = 1'b0;

    case (r_state)
      T0: begin
        if (run) begin
          w_next = T1;
        end
      end

      T1: begin
        if (w_illegal) begin
          done   = 1'b1;
          w_next = T0;
        end else begin
          case (w_opcode)
            OP_MV: begin
              bus_sel = {1'b0, w_ry};
              r_in    = w_rx_onehot;
              done    = 1'b1;
              w_next  = T0;
            end
            OP_MVI: begin
              bus_sel = SEL_D;
              r_in    = w_rx_onehot;
              done    = 1'b1;
              w_next  = T0;
            end
            OP_MVT: begin
              bus_sel = SEL_DT;
              r_in    = w_rx_onehot;
              done    = 1'b1;
              w_next  = T0;
            end
            default: begin
              // add/sub/and: capture rX into A now, so rX == rY still sees
              // the original operand when G is computed in T2.
              bus_sel = {1'b0, w_rx};
              a_in    = 1'b1;
              w_next  = T2;
            end
          endcase
        end
      end

      T2: begin
        bus_sel = {1'b0, w_ry};
        g_in    = 1'b1;
        alu_op  = alu_op_of(w_opcode);
        w_next  = T3;
      end

      T3: begin
        bus_sel = SEL_G;
        r_in    = w_rx_onehot;
        done    = 1'b1;
        w_next  = T0;
      end

      default: begin
        w_next = T0;
      end
    endcase
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_proc_control_fsm
//   Self-checking bench for proc_control_fsm. The reference model expands
//   each accepted instruction into the list of per-cycle output records it
//   must produce and plays them back one per clock; an empty list means the
//   controller is idle and every output is zero.
// ---------------------------------------------------------------------------
module tb_proc_control_fsm;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic [15:0] ir;
  logic [3:0]  bus_sel;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic [1:0]  alu_op;
  logic        done;

  proc_control_fsm #(
    .IR_W(16),
    .NREG(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .instr  (instr),
    .ir     (ir),
    .bus_sel(bus_sel),
    .r_in   (r_in),
    .a_in   (a_in),
    .g_in   (g_in),
    .alu_op (alu_op),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] rin;
    logic       a;
    logic       g;
    logic [1:0] op;
    logic       dn;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_ir;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t rec(input int sel, input int rin, input int a,
                               input int g, input int op, input int dn);
    exp_t e;
    e.sel = 4'(sel);
    e.rin = 8'(rin);
    e.a   = 1'(a);
    e.g   = 1'(g);
    e.op  = 2'(op);
    e.dn  = 1'(dn);
    return e;
  endfunction

  // Expand one instruction into its expected output cycles.
  task automatic push_instr(input logic [15:0] w);
    int op, rx, ry, onehot;
    op     = int'(w[15:13]);
    rx     = int'(w[11:9]);
    ry     = int'(w[2:0]);
    onehot = 1 << rx;
    case (op)
      0: q.push_back(rec(ry, onehot, 0, 0, 0, 1));
      1: q.push_back(rec(9, onehot, 0, 0, 0, 1));
      4: q.push_back(rec(10, onehot, 0, 0, 0, 1));
      2, 3, 5: begin
        q.push_back(rec(rx, 0, 1, 0, 0, 0));
        q.push_back(rec(ry, 0, 0, 1, (op == 2) ? 0 : (op == 3) ? 1 : 2, 0));
        q.push_back(rec(8, onehot, 0, 0, 0, 1));
      end
      default: q.push_back(rec(0, 0, 0, 0, 0, 1));
    endcase
  endtask

  // One clock: check current outputs, then drive inputs for the next edge
  // and advance the model accordingly.
  task automatic step(input logic rst_i, input logic run_i, input logic [15:0] instr_i);
    exp_t e;
    @(negedge clk);
    e = (q.size() > 0) ? q[0] : '0;
    chk("bus_sel", 32'(bus_sel), 32'(e.sel));
    chk("r_in",    32'(r_in),    32'(e.rin));
    chk("a_in",    32'(a_in),    32'(e.a));
    chk("g_in",    32'(g_in),    32'(e.g));
    chk("alu_op",  32'(alu_op),  32'(e.op));
    chk("done",    32'(done),    32'(e.dn));
    chk("ir",      32'(ir),      32'(m_ir));
    chk("r_in_onehot0", 32'($onehot0(r_in)), 32'd1);
    chk("done_excl", 32'(done & (a_in | g_in)), 32'd0);
    reset = rst_i;
    run   = run_i;
    instr = instr_i;
    if (rst_i) begin
      q.delete();
      m_ir = 16'h0000;
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (run_i) begin
      m_ir = instr_i;
      push_instr(instr_i);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ir    = 16'h0000;
    reset   = 1'b1;
    run     = 1'b0;
    instr   = 16'hFFFF;
    repeat (2) @(posedge clk);

    // Reset state, then release
    step(1'b1, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0000);

    // Reset in the middle of an add (asserted during T2)
    step(1'b0, 1'b1, 16'h4601);
    step(1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    // mvi r1, #5
    step(1'b0, 1'b1, 16'h2205);
    step(1'b0, 1'b0, 16'h0000);

    // add r3, r1
    step(1'b0, 1'b1, 16'h4601);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    // sub r7, r7
    step(1'b0, 1'b1, 16'h6E07);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);

    // mvt r2 then illegal, back-to-back; instr/run wiggle during T1
    step(1'b0, 1'b1, 16'h84AB);
    step(1'b0, 1'b1, 16'h5555);
    step(1'b0, 1'b1, 16'hE000);
    step(1'b0, 1'b1, 16'hAAAA);

    // run low for 10 cycles
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'(i * 16'h1111));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           16'($urandom));
    end
    step(1'b0, 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
